// File: rtl/aes_gcm_rx_deframer.sv
// Wire-frame deframer: length header -> 0-cycle payload pass-through (rx_ready follows pl_ready) -> tag word.
// Header/tag bytes accepted 1/cycle, one bubble per frame; optional stats counters under AES_GCM_DEFRAMER_STATS_EN.
module aes_gcm_rx_deframer #(
  parameter int TAG_WIDTH = 128,
  parameter int LEN_WIDTH = 16,
  parameter int MAX_LEN   = 1500
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx_valid,
  input  logic [7:0]           i_rx_byte,
  input  logic                 i_rx_last,
  output logic                 o_rx_ready,
  output logic                 o_pl_valid,
  output logic [7:0]           o_pl_byte,
  output logic                 o_pl_last,
  input  logic                 i_pl_ready,
  output logic [TAG_WIDTH-1:0] o_tag_in,
  output logic                 o_tag_in_valid,
  output logic                 o_frame_err,
  output logic                 o_busy,
  output logic [15:0]          o_frame_cnt,
  output logic [15:0]          o_err_cnt
);

  localparam int TAG_BYTES = TAG_WIDTH / 8;
  localparam int TCW       = $clog2(TAG_BYTES + 1);
  localparam logic [TCW-1:0] TAG_BYTES_W = TCW'(TAG_BYTES);
  localparam logic [15:0]    MAX_LEN_W   = 16'(MAX_LEN);

  typedef enum logic [2:0] {S_HDR0, S_HDR1, S_PAY, S_TAG, S_DONE, S_FLUSH} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [7:0]             r_len_hi;
  logic [LEN_WIDTH-1:0]   r_pay_cnt;
  logic [TCW-1:0]         r_tag_cnt;
  logic [TAG_WIDTH-1:0]   r_tag_sr;
  logic [TAG_WIDTH-1:0]   r_tag_in;
  logic                   r_frame_err;

  logic                   w_acc;
  logic                   w_err;
  logic [15:0]            w_len;
  logic                   w_len_bad;
  logic                   w_pay_one;
  logic                   w_tag_one;
  logic [TAG_WIDTH-1:0]   w_tag_nxt;

  assign w_acc     = i_rx_valid && o_rx_ready;
  assign w_len     = {r_len_hi, i_rx_byte};
  assign w_len_bad = (w_len == 16'd0) || (w_len > MAX_LEN_W);
  assign w_pay_one = (r_pay_cnt == LEN_WIDTH'(1));
  assign w_tag_one = (r_tag_cnt == TCW'(1));
  // First wire byte ends up in the MSBs after TAG_BYTES shifts.
  assign w_tag_nxt = (r_tag_sr << 8) | {{(TAG_WIDTH-8){1'b0}}, i_rx_byte};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_HDR0;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_rx_ready  = 1'b0;
    o_pl_valid  = 1'b0;
    o_pl_byte   = 8'd0;
    o_pl_last   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_HDR0: begin
        o_rx_ready = 1'b1;
        if (i_rx_valid) begin
          if (i_rx_last) w_err = 1'b1;
          else           w_state_nxt = S_HDR1;
        end
      end
      S_HDR1: begin
        o_rx_ready = 1'b1;
        if (i_rx_valid) begin
          if (i_rx_last) begin
            w_err       = 1'b1;
            w_state_nxt = S_HDR0;
          end else if (w_len_bad) begin
            w_err       = 1'b1;
            w_state_nxt = S_FLUSH;
          end else begin
            w_state_nxt = S_PAY;
          end
        end
      end
      S_PAY: begin
        o_rx_ready = i_pl_ready;
        o_pl_valid = i_rx_valid;
        o_pl_byte  = i_rx_byte;
        o_pl_last  = i_rx_valid && (w_pay_one || i_rx_last);
        if (i_rx_valid && i_pl_ready) begin
          if (i_rx_last) begin
            w_err       = 1'b1;
            w_state_nxt = S_HDR0;
          end else if (w_pay_one) begin
            w_state_nxt = S_TAG;
          end
        end
      end
      S_TAG: begin
        o_rx_ready = 1'b1;
        if (i_rx_valid) begin
          if (w_tag_one) begin
            if (i_rx_last) begin
              w_state_nxt = S_DONE;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = S_FLUSH;
            end
          end else if (i_rx_last) begin
            w_err       = 1'b1;
            w_state_nxt = S_HDR0;
          end
        end
      end
      S_DONE: w_state_nxt = S_HDR0;
      S_FLUSH: begin
        o_rx_ready = 1'b1;
        if (i_rx_valid && i_rx_last) w_state_nxt = S_HDR0;
      end
      default: w_state_nxt = S_HDR0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len_hi    <= 8'd0;
      r_pay_cnt   <= '0;
      r_tag_cnt   <= '0;
      r_tag_sr    <= '0;
      r_tag_in    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_acc) begin
        case (r_state)
          S_HDR0: r_len_hi <= i_rx_byte;
          S_HDR1: r_pay_cnt <= w_len[LEN_WIDTH-1:0];
          S_PAY: begin
            r_pay_cnt <= r_pay_cnt - LEN_WIDTH'(1);
            if (w_pay_one) r_tag_cnt <= TAG_BYTES_W;
          end
          S_TAG: begin
            r_tag_sr  <= w_tag_nxt;
            r_tag_cnt <= r_tag_cnt - TCW'(1);
            // Publish on acceptance so tag_in is already valid during the S_DONE pulse.
            if (w_tag_one && i_rx_last) r_tag_in <= w_tag_nxt;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_tag_in       = r_tag_in;
  assign o_tag_in_valid = (r_state == S_DONE);
  assign o_frame_err    = r_frame_err;
  assign o_busy         = (r_state != S_HDR0);

`ifdef AES_GCM_DEFRAMER_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
    end else begin
      if (r_state == S_DONE) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (r_frame_err)       r_err_cnt   <= r_err_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_err_cnt   = r_err_cnt;
`else
  assign o_frame_cnt = 16'd0;
  assign o_err_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_aes_gcm_rx_deframer.sv
// Scoreboard bench for aes_gcm_rx_deframer: expected payload bytes/tags queued at drive time, popped at the DUT outputs.
module tb_aes_gcm_rx_deframer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_byte = 8'd0;
  logic         rx_last = 1'b0;
  logic         pl_ready = 1'b1;
  logic         rx_ready;
  logic         pl_valid;
  logic [7:0]   pl_byte;
  logic         pl_last;
  logic [127:0] tag_in;
  logic         tag_in_valid;
  logic         frame_err;
  logic         busy;
  logic [15:0]  frame_cnt;
  logic [15:0]  err_cnt;

`ifdef AES_GCM_DEFRAMER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  aes_gcm_rx_deframer dut (
    .i_clk(clk), .i_rst(rst),
    .i_rx_valid(rx_valid), .i_rx_byte(rx_byte), .i_rx_last(rx_last), .o_rx_ready(rx_ready),
    .o_pl_valid(pl_valid), .o_pl_byte(pl_byte), .o_pl_last(pl_last), .i_pl_ready(pl_ready),
    .o_tag_in(tag_in), .o_tag_in_valid(tag_in_valid), .o_frame_err(frame_err), .o_busy(busy),
    .o_frame_cnt(frame_cnt), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [8:0]   exp_pl[$];
  logic [127:0] exp_tag[$];
  int err_seen = 0;
  int exp_err  = 0;
  int exp_fcnt = 0;
  int exp_ecnt = 0;
  bit bp = 1'b0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pl_valid) chk("rdy_mirror", 128'(rx_ready), 128'(pl_ready));
      if (pl_valid && pl_ready) begin
        chk("pl_expected", 128'(exp_pl.size() > 0), 128'd1);
        if (exp_pl.size() > 0) chk("pl_dat", 128'({pl_last, pl_byte}), 128'(exp_pl.pop_front()));
      end
      if (tag_in_valid) begin
        chk("tag_expected", 128'(exp_tag.size() > 0), 128'd1);
        if (exp_tag.size() > 0) chk("tag_in", tag_in, exp_tag.pop_front());
      end
      if (frame_err || tag_in_valid) chk("err_tag_excl", 128'(frame_err && tag_in_valid), 128'd0);
      if (frame_err) err_seen++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    int  n = 0;
    logic acc = 1'b0;
    rx_valid = 1'b1;
    rx_byte  = b;
    rx_last  = l;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk);
      #1;
      n++;
      if (bp) pl_ready = ~pl_ready;
    end
    if (!acc) chk("rx_accept_timeout", 128'(acc), 128'd1);
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic frame(input int len, input logic [7:0] pseed, input logic [7:0] tseed, input bit tag_last);
    logic [127:0] t = '0;
    logic [7:0]   b;
    for (int i = 0; i < 16; i++) t = {t[119:0], tseed + 8'(i)};
    send(8'(len >> 8), 1'b0);
    send(8'(len), 1'b0);
    for (int i = 0; i < len; i++) begin
      b = pseed + 8'(i * 17);
      exp_pl.push_back({i == len - 1, b});
      send(b, 1'b0);
    end
    if (tag_last) begin
      exp_tag.push_back(t);
      exp_fcnt++;
    end else begin
      exp_err++;
      exp_ecnt++;
    end
    for (int i = 0; i < 16; i++) send(tseed + 8'(i), tag_last && (i == 15));
  endtask

  task automatic check_end(input string tag);
    idle(3);
    chk({tag, "_err_pulses"}, 128'(err_seen), 128'(exp_err));
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_frame_cnt"}, 128'(frame_cnt), STATS ? 128'(16'(exp_fcnt)) : 128'd0);
    chk({tag, "_err_cnt"}, 128'(err_cnt), STATS ? 128'(16'(exp_ecnt)) : 128'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rx_ready"}, 128'(rx_ready), 128'd1);
    chk({tag, "_pl_valid"}, 128'(pl_valid), 128'd0);
    chk({tag, "_pl_last"}, 128'(pl_last), 128'd0);
    chk({tag, "_pl_byte"}, 128'(pl_byte), 128'd0);
    chk({tag, "_tag_in"}, tag_in, 128'd0);
    chk({tag, "_tag_vld"}, 128'(tag_in_valid), 128'd0);
    chk({tag, "_frame_err"}, 128'(frame_err), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_frame_cnt"}, 128'(frame_cnt), 128'd0);
    chk({tag, "_err_cnt"}, 128'(err_cnt), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("rst0");

    // Good frame: AA BB CC, tag 00..0F
    frame(3, 8'hAA, 8'h00, 1'b1);
    check_end("good");
    chk("good_tag_lit", tag_in, 128'h000102030405060708090a0b0c0d0e0f);

    // Zero length, then 5 bytes flushed
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    exp_err++; exp_ecnt++;
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), i == 4);
    check_end("zero_len");

    // Truncated payload: length 8, rx_last on the 4th byte
    send(8'h00, 1'b0);
    send(8'h08, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_pl.push_back({i == 3, 8'h50 + 8'(i)});
      send(8'h50 + 8'(i), i == 3);
    end
    exp_err++; exp_ecnt++;
    check_end("trunc");
    chk("trunc_tag_hold", tag_in, 128'h000102030405060708090a0b0c0d0e0f);

    // rx_last on the first header byte
    send(8'h00, 1'b1);
    exp_err++; exp_ecnt++;
    check_end("hdr0_last");

    // Length MAX_LEN+1 with rx_last on the second header byte
    send(8'h05, 1'b0);
    send(8'hDD, 1'b1);
    exp_err++; exp_ecnt++;
    check_end("too_long");

    // Minimum legal payload
    frame(1, 8'h5A, 8'h80, 1'b1);
    check_end("len1");

    // Back-pressure with pl_ready toggling
    bp = 1'b1;
    pl_ready = 1'b1;
    frame(10, 8'h10, 8'hC0, 1'b1);
    bp = 1'b0;
    pl_ready = 1'b1;
    check_end("bp");

    // Missing rx_last on final tag byte, junk, then a good frame
    frame(3, 8'h21, 8'h40, 1'b0);
    for (int i = 0; i < 3; i++) send(8'hE0 + 8'(i), i == 2);
    check_end("no_last");
    frame(4, 8'h07, 8'hA0, 1'b1);
    check_end("after_flush");

    // Reset after 2 of 5 payload bytes
    send(8'h00, 1'b0);
    send(8'h05, 1'b0);
    exp_pl.push_back({1'b0, 8'h61});
    send(8'h61, 1'b0);
    exp_pl.push_back({1'b0, 8'h72});
    send(8'h72, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_fcnt = 0;
    exp_ecnt = 0;
    check_reset("rst_mid");
    frame(5, 8'h90, 8'h33, 1'b1);
    check_end("after_rst");

    idle(5);
    chk("pl_q_empty", 128'(exp_pl.size()), 128'd0);
    chk("tag_q_empty", 128'(exp_tag.size()), 128'd0);
    chk("final_err_pulses", 128'(err_seen), 128'(exp_err));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
